// File: rtl/stack_pkg.sv
// Shared types and constants for the stack operation sequencer.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_ADJ  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [3:0] ESP_LOAD = 4'h1;
  localparam logic [3:0] ESP_HOLD = 4'h0;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] WORD_STEP  = 32'(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_ESP,
    ST_PUSH_MEM,
    ST_POP_MEM,
    ST_POP_ESP,
    ST_ADJ_ESP,
    ST_DONE
  } state_t;

  // A stack pointer is legal only on a whole-word boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr & (WORD_STEP - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/stack_range_check.sv
// Combinational bounds/alignment check and new-ESP computation for one op.
module stack_range_check
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_LOW = 32'h0000_1000,
  parameter logic [31:0] STACK_TOP = 32'h0001_0000
) (
  input  logic [31:0] sp,
  input  logic [1:0]  code,
  input  logic [31:0] data,
  output logic        fault,
  output logic [31:0] sp_new
);

  logic [31:0] push_sp;
  logic [32:0] pop_end;
  logic [31:0] adj_sp;

  assign push_sp = sp - WORD_STEP;
  // Carry bit kept so an ESP near 2^32 cannot wrap past the top check.
  assign pop_end = {1'b0, sp} + {1'b0, WORD_STEP};
  assign adj_sp  = sp + data;

  // Select the new pointer and decide whether the op must be aborted.
  always_comb begin
    fault  = 1'b0;
    sp_new = sp;
    case (code)
      OP_PUSH: begin
        sp_new = push_sp;
        fault  = !is_word_aligned(sp) || (sp < (STACK_LOW + WORD_STEP));
      end
      OP_POP: begin
        sp_new = pop_end[31:0];
        fault  = !is_word_aligned(sp) || (pop_end > {1'b0, STACK_TOP});
      end
      OP_ADJ: begin
        sp_new = adj_sp;
        fault  = (adj_sp < STACK_LOW) || (adj_sp > STACK_TOP);
      end
      OP_RSV: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequences PUSH / POP / ESP-adjust ops against the ESP register and the
// data-memory port, one op at a time, with bounds checking at accept.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | op_ready=1, waiting for op_valid
//   ST_PUSH_ESP  | load ESP with sp-4 (one cycle)
//   ST_PUSH_MEM  | write data to sp-4, held until mem_ack
//   ST_POP_MEM   | read from sp, held until mem_ack
//   ST_POP_ESP   | load ESP with sp+4 (one cycle)
//   ST_ADJ_ESP   | load ESP with sp+data (one cycle)
//   ST_DONE      | done pulse, fault/result valid
module stack_op_sequencer
  import stack_pkg::*;
#(
  parameter logic [31:0] STACK_LOW = 32'h0000_1000,
  parameter logic [31:0] STACK_TOP = 32'h0001_0000
) (
  input  logic        clock_5,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_data,
  input  logic [31:0] esp,
  output logic [3:0]  esp_rw,
  output logic [31:0] esp_next,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        fault,
  output logic [31:0] result
);

  state_t      state;
  logic [31:0] data_q;
  logic [31:0] sp_new_q;
  logic [31:0] rdata_q;
  logic        chk_fault;
  logic [31:0] chk_sp_new;

  // Checks run on the live ESP/op inputs; they are only consumed on the
  // accept cycle, so the result is the check of the captured values.
  stack_range_check #(
    .STACK_LOW(STACK_LOW),
    .STACK_TOP(STACK_TOP)
  ) u_range_check (
    .sp     (esp),
    .code   (op_code),
    .data   (op_data),
    .fault  (chk_fault),
    .sp_new (chk_sp_new)
  );

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_ready  <= 1'b1;
      esp_rw    <= ESP_HOLD;
      esp_next  <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      done      <= 1'b0;
      fault     <= 1'b0;
      result    <= 32'h0;
      data_q    <= 32'h0;
      sp_new_q  <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            data_q   <= op_data;
            sp_new_q <= chk_sp_new;
            if (chk_fault) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              fault  <= 1'b1;
              result <= 32'h0;
            end else begin
              unique case (op_code)
                OP_PUSH: begin
                  state    <= ST_PUSH_ESP;
                  esp_rw   <= ESP_LOAD;
                  esp_next <= chk_sp_new;
                end
                OP_POP: begin
                  state    <= ST_POP_MEM;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= esp;
                end
                OP_ADJ: begin
                  state    <= ST_ADJ_ESP;
                  esp_rw   <= ESP_LOAD;
                  esp_next <= chk_sp_new;
                end
                default: begin
                  // Reserved code never passes the check; kept for safety.
                  state <= ST_DONE;
                  done  <= 1'b1;
                  fault <= 1'b1;
                end
              endcase
            end
          end
        end

        ST_PUSH_ESP: begin
          esp_rw    <= ESP_HOLD;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= sp_new_q;
          mem_wdata <= data_q;
          state     <= ST_PUSH_MEM;
        end

        ST_PUSH_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b0;
            result  <= 32'h0;
            state   <= ST_DONE;
          end
        end

        ST_POP_MEM: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            rdata_q  <= mem_rdata;
            esp_rw   <= ESP_LOAD;
            esp_next <= sp_new_q;
            state    <= ST_POP_ESP;
          end
        end

        ST_POP_ESP: begin
          esp_rw <= ESP_HOLD;
          done   <= 1'b1;
          fault  <= 1'b0;
          result <= rdata_q;
          state  <= ST_DONE;
        end

        ST_ADJ_ESP: begin
          esp_rw <= ESP_HOLD;
          done   <= 1'b1;
          fault  <= 1'b0;
          result <= 32'h0;
          state  <= ST_DONE;
        end

        ST_DONE: begin
          done     <= 1'b0;
          fault    <= 1'b0;
          result   <= 32'h0;
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
          esp_rw   <= ESP_HOLD;
          mem_req  <= 1'b0;
          done     <= 1'b0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with hand-computed expectations.
module tb_stack_op_sequencer;
  import stack_pkg::*;

  logic        clock_5 = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_data = 32'h0;
  logic [31:0] esp = 32'h0;
  logic [3:0]  esp_rw;
  logic [31:0] esp_next;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        done;
  logic        fault;
  logic [31:0] result;

  stack_op_sequencer dut (
    .clock_5   (clock_5),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_data   (op_data),
    .esp       (esp),
    .esp_rw    (esp_rw),
    .esp_next  (esp_next),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .done      (done),
    .fault     (fault),
    .result    (result)
  );

  always #5 clock_5 = ~clock_5;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory responder and observation counters, sampled on the falling edge.
  int          ack_delay = 0;
  logic [31:0] rdata_val = 32'h0;
  int          wait_cnt = 0;
  int          cyc = 0;
  int          n_load = 0, n_bad_rw = 0, n_req = 0, n_unstable = 0;
  int          n_done = 0, n_fault = 0, n_acc = 0, n_wr = 0, n_ready_busy = 0;
  int          acc_cyc = 0, done_cyc = 0;
  logic        busy = 1'b0, prev_req = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, last_esp_next = 32'h0;
  logic [31:0] last_result = 32'h0, wr_xor = 32'h0, last_wr_addr = 32'h0;
  logic        last_fault = 1'b0;

  initial begin
    forever begin
      @(negedge clock_5);
      cyc++;
      if (!reset) busy = 1'b0;
      if (mem_req) begin
        mem_ack   = (wait_cnt == ack_delay);
        mem_rdata = mem_ack ? rdata_val : 32'h0;
        wait_cnt++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt  = 0;
      end
      if (esp_rw == ESP_LOAD) begin
        n_load++;
        last_esp_next = esp_next;
      end else if (esp_rw != ESP_HOLD) n_bad_rw++;
      if (mem_req) begin
        if (!prev_req) begin
          req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
        end else if (mem_addr != req_addr || mem_we != req_we ||
                     (mem_we && mem_wdata != req_wdata)) n_unstable++;
        n_req++;
        if (mem_ack && mem_we) begin
          n_wr++; wr_xor = wr_xor ^ mem_wdata; last_wr_addr = mem_addr;
        end
      end
      prev_req = mem_req;
      if (busy && op_ready) n_ready_busy++;
      if (fault && !done) n_bad_rw++;
      if (done) begin
        n_done++; done_cyc = cyc; last_fault = fault; last_result = result;
        if (fault) n_fault++;
        busy = 1'b0;
      end
      if (op_valid && op_ready) begin
        n_acc++; acc_cyc = cyc; busy = 1'b1;
      end
    end
  end

  int b_load, b_req, b_unstable, b_done, b_fault, b_acc, b_wr, b_busy;
  logic [31:0] b_xor;

  task automatic snap();
    b_load = n_load; b_req = n_req; b_unstable = n_unstable; b_done = n_done;
    b_fault = n_fault; b_acc = n_acc; b_wr = n_wr; b_busy = n_ready_busy; b_xor = wr_xor;
  endtask

  task automatic step();
    @(posedge clock_5);
    #2;
  endtask

  task automatic run_op(input logic [1:0] c, input logic [31:0] d, input logic [31:0] sp,
                        input int dly, input logic [31:0] rd);
    snap();
    ack_delay = dly; rdata_val = rd;
    op_code = c; op_data = d; esp = sp; op_valid = 1'b1;
    for (int i = 0; i < 10 && n_acc == b_acc; i++) step();
    op_valid = 1'b0;
    for (int i = 0; i < 20 && n_done == b_done; i++) step();
    step();
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  code;
    logic [31:0] data;
    logic [31:0] sp;
  } fvec_t;

  fvec_t fvec [4];

  initial begin
    fvec[0] = '{"flt_push_align", OP_PUSH, 32'h0000_0000, 32'h0000_1002};
    fvec[1] = '{"flt_pop_top",    OP_POP,  32'h0000_0000, 32'h0001_0000};
    fvec[2] = '{"flt_adj_low",    OP_ADJ,  32'hFFFF_FFF0, 32'h0000_1008};
    fvec[3] = '{"flt_rsv",        OP_RSV,  32'h0000_0000, 32'h0000_8000};

    #12;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_esp_rw", 32'(esp_rw), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_esp_next", esp_next, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    step();
    reset = 1'b1;
    step();

    // PUSH with ack two cycles late
    run_op(OP_PUSH, 32'hDEAD_BEEF, 32'h0000_8000, 2, 32'h0);
    chk("push_accept", 32'(n_acc - b_acc), 32'd1);
    chk("push_latency", 32'(done_cyc - acc_cyc), 32'd5);
    chk("push_esp_loads", 32'(n_load - b_load), 32'd1);
    chk("push_esp_next", last_esp_next, 32'h0000_7FFC);
    chk("push_addr", req_addr, 32'h0000_7FFC);
    chk("push_we", 32'(req_we), 32'd1);
    chk("push_wdata", req_wdata, 32'hDEAD_BEEF);
    chk("push_req_cycles", 32'(n_req - b_req), 32'd3);
    chk("push_stable", 32'(n_unstable - b_unstable), 32'd0);
    chk("push_fault", 32'(last_fault), 32'd0);
    chk("push_result", last_result, 32'h0);

    // POP acked immediately
    run_op(OP_POP, 32'h0, 32'h0000_7FFC, 0, 32'h1234_5678);
    chk("pop_latency", 32'(done_cyc - acc_cyc), 32'd3);
    chk("pop_addr", req_addr, 32'h0000_7FFC);
    chk("pop_we", 32'(req_we), 32'd0);
    chk("pop_esp_loads", 32'(n_load - b_load), 32'd1);
    chk("pop_esp_next", last_esp_next, 32'h0000_8000);
    chk("pop_result", last_result, 32'h1234_5678);
    chk("pop_fault", 32'(last_fault), 32'd0);

    // Bound / alignment / reserved faults
    for (int k = 0; k < 4; k++) begin
      run_op(fvec[k].code, fvec[k].data, fvec[k].sp, 0, 32'h0);
      chk({fvec[k].tag, "_fault"}, 32'(last_fault), 32'd1);
      chk({fvec[k].tag, "_latency"}, 32'(done_cyc - acc_cyc), 32'd1);
      chk({fvec[k].tag, "_no_req"}, 32'(n_req - b_req), 32'd0);
      chk({fvec[k].tag, "_no_load"}, 32'(n_load - b_load), 32'd0);
    end

    // ADJ forward by 16
    run_op(OP_ADJ, 32'h0000_0010, 32'h0000_8000, 0, 32'h0);
    chk("adj_esp_next", last_esp_next, 32'h0000_8010);
    chk("adj_latency", 32'(done_cyc - acc_cyc), 32'd2);
    chk("adj_esp_loads", 32'(n_load - b_load), 32'd1);
    chk("adj_no_req", 32'(n_req - b_req), 32'd0);
    chk("adj_fault", 32'(last_fault), 32'd0);

    // Reset while PUSH waits for ack
    snap();
    ack_delay = 1000;
    op_code = OP_PUSH; op_data = 32'hCAFE_0001; esp = 32'h0000_8000; op_valid = 1'b1;
    for (int i = 0; i < 10 && n_acc == b_acc; i++) step();
    op_valid = 1'b0;
    for (int i = 0; i < 10 && n_req == b_req; i++) step();
    step();
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_ready", 32'(op_ready), 32'd1);
    chk("rst_mid_esp_rw", 32'(esp_rw), 32'd0);
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("rst_mid_no_done", 32'(n_done - b_done), 32'd0);
    chk("rst_mid_loads", 32'(n_load - b_load), 32'd1);

    run_op(OP_POP, 32'h0, 32'h0000_7FFC, 0, 32'hAABB_CCDD);
    chk("post_rst_pop_result", last_result, 32'hAABB_CCDD);
    chk("post_rst_pop_latency", 32'(done_cyc - acc_cyc), 32'd3);

    // Three PUSHes with op_valid held high
    snap();
    ack_delay = 0;
    esp = 32'h0000_8000;
    op_code = OP_PUSH; op_data = 32'h1111_1111; op_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20 && n_acc < b_acc + k + 1; i++) begin
        step();
        if (n_load != b_load) esp = last_esp_next;
      end
      if (k == 0) op_data = 32'h2222_2222;
      else if (k == 1) op_data = 32'h4444_4444;
      else op_valid = 1'b0;
    end
    for (int i = 0; i < 20 && n_done < b_done + 3; i++) step();
    repeat (3) step();
    chk("hs_accepts", 32'(n_acc - b_acc), 32'd3);
    chk("hs_dones", 32'(n_done - b_done), 32'd3);
    chk("hs_faults", 32'(n_fault - b_fault), 32'd0);
    chk("hs_loads", 32'(n_load - b_load), 32'd3);
    chk("hs_writes", 32'(n_wr - b_wr), 32'd3);
    chk("hs_wdata_xor", wr_xor ^ b_xor, 32'h7777_7777);
    chk("hs_last_addr", last_wr_addr, 32'h0000_7FF4);
    chk("hs_final_esp", last_esp_next, 32'h0000_7FF4);
    chk("hs_ready_low_busy", 32'(n_ready_busy - b_busy), 32'd0);

    chk("esp_rw_illegal_or_stray_fault", 32'(n_bad_rw), 32'd0);
    chk("ready_high_while_busy", 32'(n_ready_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
Sequences stack operations (PUSH, POP, ESP adjust) against the ESP register and the data-memory port. Accepts one op at a time from decode via a valid/ready handshake. Drives the ESP register's 4-bit read_or_write code and its 32-bit load value, and runs one memory transaction per PUSH or POP. Checks stack bounds and alignment, and reports completion or fault.

Parameters:
STACK_LOW, 32'h0000_1000, lowest legal ESP value (inclusive)
STACK_TOP, 32'h0001_0000, highest legal ESP value (inclusive; empty-stack ESP)
WORD_BYTES, 4, ESP step per PUSH/POP

Ports:
clock_5  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op_valid  in  1  op request
op_ready  out  1  sequencer idle, can accept op
op_code  in  2  00 PUSH, 01 POP, 10 ADJ, 11 reserved
op_data  in  32  PUSH value / ADJ signed offset
esp  in  32  current ESP register value
esp_rw  out  4  ESP register control: 4'h1 load esp_next, 4'h0 hold
esp_next  out  32  value loaded into ESP when esp_rw==4'h1
mem_req  out  1  memory request
mem_we  out  1  1 write, 0 read
mem_addr  out  32  byte address
mem_wdata  out  32  write data
mem_ack  in  1  memory completes the request this cycle
mem_rdata  in  32  read data, valid with mem_ack
done  out  1  1-cycle completion pulse
fault  out  1  1-cycle pulse with done; op aborted
result  out  32  POP data; valid while done=1

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; op_ready=1; esp_rw=4'h0; mem_req=0; mem_we=0; done=0; fault=0; result=0; esp_next=0; mem_addr=0; mem_wdata=0. Reset takes effect mid-operation too: mem_req drops immediately and no ESP load is issued.
- Accept: op_valid && op_ready in IDLE. Capture sp=esp, code, and data. op_ready=0 from the next cycle until the cycle after DONE.
- States: IDLE, PUSH_ESP, PUSH_MEM, POP_MEM, POP_ESP, ADJ_ESP, DONE.
- Range and alignment checks are evaluated on the captured sp at accept time. On a failing check the next state is DONE with fault=1, with no ESP load and no memory access.
  - PUSH fails if sp[1:0]!=0 or sp < STACK_LOW+4.
  - POP fails if sp[1:0]!=0 or sp+4 > STACK_TOP.
  - ADJ fails if (sp+data mod 2^32) is outside [STACK_LOW, STACK_TOP].
  - Reserved op_code always fails.
- PUSH:
  - PUSH_ESP (1 cycle): esp_rw=4'h1, esp_next=sp-4.
  - PUSH_MEM: mem_req=1, mem_we=1, mem_addr=sp-4, mem_wdata=data, all held stable until mem_ack; then go to DONE.
- POP:
  - POP_MEM: mem_req=1, mem_we=0, mem_addr=sp, held until mem_ack; capture mem_rdata into result.
  - POP_ESP (1 cycle): esp_rw=4'h1, esp_next=sp+4; then go to DONE.
- ADJ: ADJ_ESP (1 cycle): esp_rw=4'h1, esp_next=sp+data (32-bit wrap); then go to DONE.
- DONE (1 cycle): done=1; fault as determined; result holds the POP data, otherwise 0. Next state is IDLE.
- mem_ack is honoured in the same cycle mem_req first rises, so the minimum wait is 0 extra cycles. mem_ack is ignored while mem_req=0.
- esp_rw equals 4'h1 in exactly one cycle per successful op and is 4'h0 at all other times.
- Latency with mem_ack at the first opportunity:
  - PUSH/POP: done 3 cycles after accept.
  - ADJ: done 2 cycles after accept.
  - Fault: done 1 cycle after accept.
- Back-to-back: the next accept is possible the cycle after DONE. The sequencer uses its own captured sp, so no ESP read-after-write hazard arises inside an op.

Decomposition:
- Package stack_pkg:
  - op_code constants OP_PUSH/OP_POP/OP_ADJ/OP_RSV
  - state encoding
  - ESP_LOAD=4'h1 and ESP_HOLD=4'h0
  - WORD_BYTES
- One natural sub-module: stack_range_check. It is combinational: given sp, code, and data, it produces fault and the new-sp value. It is shared with the verification model.

Test Plan:
- PUSH op_data=32'hDEADBEEF with esp=32'h0000_8000, mem_ack 2 cycles late -> esp_rw=4'h1 for exactly one cycle with esp_next=32'h0000_7FFC; mem write to 32'h0000_7FFC with data DEADBEEF held until ack; done 5 cycles after accept; fault=0.
- POP with esp=32'h0000_7FFC, mem_rdata=32'h1234_5678 acked immediately -> read at 32'h0000_7FFC; esp_next=32'h0000_8000; done with result=32'h1234_5678 3 cycles after accept.
- Bounds: PUSH at esp=32'h0000_1002 -> fault (alignment). POP at esp=STACK_TOP=32'h0001_0000 -> fault. ADJ data=32'hFFFF_FFF0 at esp=32'h0000_1008 -> fault. In all three cases, no mem_req and esp_rw never 4'h1.
- ADJ data=32'h0000_0010 at esp=32'h0000_8000 -> esp_next=32'h0000_8010, done 2 cycles after accept; reserved op_code=2'b11 -> fault.
- Reset asserted (reset=0) while in PUSH_MEM awaiting ack -> mem_req=0 asynchronously, op_ready=1, no done pulse; a later op proceeds normally.
- Handshake: hold op_valid high with 3 queued PUSHes -> exactly one accept per op_ready window; op_ready=0 during each op; 3 done pulses, no op dropped or duplicated.
